// File: rtl/ysyx_22041412_csr_file.sv
// Machine-mode CSR file and trap sequencer: Zicsr access, ecall/mret, timer-interrupt entry
// and fetch redirect, served one request per two cycles through a two-state handshake FSM.
module ysyx_22041412_csr_file #(
  parameter int unsigned       XLEN        = 64,
  parameter logic [XLEN-1:0]   MSTATUS_RST = 64'ha00001800,
  parameter logic [XLEN-1:0]   MTVEC_RST   = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      cmd_i,
  input  logic [2:0]      func3_i,
  input  logic [11:0]     addr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] data_i,
  output logic            rvalid_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            illegal_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  input  logic            mtip_i,
  output logic            irq_o,
  input  logic            irq_ack_i
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;

  localparam logic [1:0] CMD_CSR   = 2'b00;
  localparam logic [1:0] CMD_ECALL = 2'b01;
  localparam logic [1:0] CMD_MRET  = 2'b10;

  localparam logic [XLEN-1:0] CAUSE_ECALL = {{(XLEN-4){1'b0}}, 4'd11};
  localparam logic [XLEN-1:0] CAUSE_MTI   = {1'b1, {(XLEN-4){1'b0}}, 3'd7};
  localparam logic [XLEN-1:0] VEC_MTI_OFF = {{(XLEN-5){1'b0}}, 5'd28};

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t state_q, state_d;

  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic            mie_mtie_q, mie_mtie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mcycle_q, mcycle_d;

  logic            rvalid_q, rvalid_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            illegal_q, illegal_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  logic [XLEN-1:0] mstatus_val, mie_val, mip_val;
  logic [XLEN-1:0] csr_old, csr_wdata, trap_base;
  logic            addr_hit, op_legal, op_force;
  logic            irq_take, accept;
  logic            is_csr, is_ecall, is_mret;
  logic            csr_illegal, req_illegal, csr_we;
  logic            ecall_go, mret_go, trap_enter;

  // Only MIE/MPIE are stored; every other mstatus bit is the reset constant.
  always_comb begin
    mstatus_val    = MSTATUS_RST;
    mstatus_val[3] = mstatus_mie_q;
    mstatus_val[7] = mstatus_mpie_q;
    mie_val        = '0;
    mie_val[7]     = mie_mtie_q;
    mip_val        = '0;
    mip_val[7]     = mtip_i;
  end

  always_comb begin
    csr_old  = '0;
    addr_hit = 1'b1;
    case (addr_i)
      A_MSTATUS:  csr_old = mstatus_val;
      A_MIE:      csr_old = mie_val;
      A_MTVEC:    csr_old = mtvec_q;
      A_MSCRATCH: csr_old = mscratch_q;
      A_MEPC:     csr_old = mepc_q;
      A_MCAUSE:   csr_old = mcause_q;
      A_MIP:      csr_old = mip_val;
      A_MCYCLE:   csr_old = mcycle_q;
      default:    addr_hit = 1'b0;
    endcase
  end

  // Set/clear forms with a zero operand read without writing.
  always_comb begin
    csr_wdata = csr_old;
    op_legal  = 1'b1;
    op_force  = 1'b0;
    case (func3_i)
      3'b001, 3'b101: begin
        csr_wdata = data_i;
        op_force  = 1'b1;
      end
      3'b010, 3'b110: csr_wdata = csr_old | data_i;
      3'b011, 3'b111: csr_wdata = csr_old & ~data_i;
      default:        op_legal  = 1'b0;
    endcase
  end

  assign irq_o    = mstatus_mie_q & mie_mtie_q & mtip_i;
  assign irq_take = irq_ack_i & irq_o & (state_q == IDLE);
  assign accept   = valid_i & ready_o;

  assign is_csr      = (cmd_i == CMD_CSR);
  assign is_ecall    = (cmd_i == CMD_ECALL);
  assign is_mret     = (cmd_i == CMD_MRET);
  assign csr_illegal = is_csr & (~op_legal | ~addr_hit);
  assign req_illegal = csr_illegal | (cmd_i == 2'b11);
  assign csr_we      = accept & is_csr & ~csr_illegal & (op_force | (data_i != '0));
  assign ecall_go    = accept & is_ecall;
  assign mret_go     = accept & is_mret;
  assign trap_enter  = irq_take | ecall_go;
  assign trap_base   = {mtvec_q[XLEN-1:2], 2'b00};

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_mtie_d     = mie_mtie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mcycle_d       = mcycle_q + 1'b1;
    if (csr_we) begin
      case (addr_i)
        A_MSTATUS: begin
          mstatus_mie_d  = csr_wdata[3];
          mstatus_mpie_d = csr_wdata[7];
        end
        A_MIE:      mie_mtie_d = csr_wdata[7];
        A_MTVEC:    mtvec_d    = {csr_wdata[XLEN-1:2], 1'b0, csr_wdata[0]};
        A_MSCRATCH: mscratch_d = csr_wdata;
        A_MEPC:     mepc_d     = {csr_wdata[XLEN-1:2], 2'b00};
        A_MCAUSE:   mcause_d   = csr_wdata;
        A_MCYCLE:   mcycle_d   = csr_wdata;
        default: ;
      endcase
    end
    if (trap_enter) begin
      mepc_d         = pc_i;
      mcause_d       = irq_take ? CAUSE_MTI : CAUSE_ECALL;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end
    if (mret_go) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end

  always_comb begin
    rvalid_d      = accept;
    illegal_d     = accept & req_illegal;
    rdata_d       = (accept & is_csr & ~csr_illegal) ? csr_old : '0;
    redirect_d    = trap_enter | mret_go;
    redirect_pc_d = '0;
    if (irq_take)
      redirect_pc_d = mtvec_q[0] ? trap_base + VEC_MTI_OFF : trap_base;
    else if (ecall_go)
      redirect_pc_d = trap_base;
    else if (mret_go)
      redirect_pc_d = mepc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_mie_q  <= MSTATUS_RST[3];
      mstatus_mpie_q <= MSTATUS_RST[7];
      mie_mtie_q     <= 1'b0;
      mtvec_q        <= MTVEC_RST;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mcycle_q       <= '0;
      rvalid_q       <= 1'b0;
      rdata_q        <= '0;
      illegal_q      <= 1'b0;
      redirect_q     <= 1'b0;
      redirect_pc_q  <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_mtie_q     <= mie_mtie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mcycle_q       <= mcycle_d;
      rvalid_q       <= rvalid_d;
      rdata_q        <= rdata_d;
      illegal_q      <= illegal_d;
      redirect_q     <= redirect_d;
      redirect_pc_q  <= redirect_pc_d;
    end
  end

  assign rvalid_o      = rvalid_q;
  assign rdata_o       = rdata_q;
  assign illegal_o     = illegal_q;
  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept | irq_take) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A taken interrupt owns the cycle, so a concurrent request waits for the next IDLE.
  always_comb begin
    ready_o = 1'b0;
    if (!rst && state_q == IDLE && !irq_take) ready_o = 1'b1;
  end

endmodule

// File: tb/tb_ysyx_22041412_csr_file.sv
// Directed bench for the CSR file: each step drives one request and checks the response
// against hand-computed values with immediate assertions.
module tb_ysyx_22041412_csr_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  cmd_i;
  logic [2:0]  func3_i;
  logic [11:0] addr_i;
  logic [63:0] pc_i;
  logic [63:0] data_i;
  logic        rvalid_o;
  logic [63:0] rdata_o;
  logic        illegal_o;
  logic        redirect_o;
  logic [63:0] redirect_pc_o;
  logic        mtip_i;
  logic        irq_o;
  logic        irq_ack_i;

  int tests_run = 0;
  int tests_failed = 0;

  ysyx_22041412_csr_file dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .cmd_i         (cmd_i),
    .func3_i       (func3_i),
    .addr_i        (addr_i),
    .pc_i          (pc_i),
    .data_i        (data_i),
    .rvalid_o      (rvalid_o),
    .rdata_o       (rdata_o),
    .illegal_o     (illegal_o),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o),
    .mtip_i        (mtip_i),
    .irq_o         (irq_o),
    .irq_ack_i     (irq_ack_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after an edge; waits one edge to leave RESP, then issues the request.
  task automatic do_req(input logic [1:0] c, input logic [2:0] f, input logic [11:0] a,
                        input logic [63:0] p, input logic [63:0] d);
    @(posedge clk); #1;
    valid_i = 1'b1; cmd_i = c; func3_i = f; addr_i = a; pc_i = p; data_i = d;
    #1;
    chk("req_ready", {63'd0, ready_o}, 64'd1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    $display("[TB] req cmd=%0d f3=%0d addr=%h data=%h -> rvalid=%0d rdata=%h ill=%0d redir=%0d pc=%h",
             c, f, a, d, rvalid_o, rdata_o, illegal_o, redirect_o, redirect_pc_o);
  endtask

  task automatic rd(input logic [11:0] a, input logic [63:0] exp, input string tag);
    do_req(2'b00, 3'b010, a, 64'd0, 64'd0);
    chk({tag, "_rvalid"}, {63'd0, rvalid_o}, 64'd1);
    chk(tag, rdata_o, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish by 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; valid_i = 1'b0; cmd_i = 2'b00; func3_i = 3'b000; addr_i = 12'h000;
    pc_i = 64'd0; data_i = 64'd0; mtip_i = 1'b0; irq_ack_i = 1'b0;

    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_ready",       {63'd0, ready_o},    64'd0);
    chk("rst_rvalid",      {63'd0, rvalid_o},   64'd0);
    chk("rst_illegal",     {63'd0, illegal_o},  64'd0);
    chk("rst_redirect",    {63'd0, redirect_o}, 64'd0);
    chk("rst_irq",         {63'd0, irq_o},      64'd0);
    chk("rst_rdata",       rdata_o,             64'd0);
    chk("rst_redirect_pc", redirect_pc_o,       64'd0);
    rst = 1'b0; #1;
    chk("post_rst_ready",  {63'd0, ready_o},    64'd1);

    // Basic read/write of mscratch
    do_req(2'b00, 3'b001, 12'h340, 64'd0, 64'h1234);
    chk("rw_rvalid",  {63'd0, rvalid_o},  64'd1);
    chk("rw_old",     rdata_o,            64'd0);
    chk("rw_illegal", {63'd0, illegal_o}, 64'd0);
    rd(12'h340, 64'h1234, "mscratch_rd");
    rd(12'h340, 64'h1234, "mscratch_keep");

    // mstatus masking
    do_req(2'b00, 3'b010, 12'h300, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("mstatus_set_old", rdata_o, 64'ha00001800);
    rd(12'h300, 64'ha00001888, "mstatus_masked");

    // ecall / mret with MIE=1, MPIE=0 before the trap
    do_req(2'b00, 3'b011, 12'h300, 64'd0, 64'h80);
    chk("mstatus_clr_old", rdata_o, 64'ha00001888);
    do_req(2'b00, 3'b001, 12'h305, 64'd0, 64'h8000_0100);
    do_req(2'b01, 3'b000, 12'h000, 64'h8000_0040, 64'd0);
    chk("ecall_redirect",    {63'd0, redirect_o}, 64'd1);
    chk("ecall_redirect_pc", redirect_pc_o,       64'h8000_0100);
    chk("ecall_rvalid",      {63'd0, rvalid_o},   64'd1);
    rd(12'h341, 64'h8000_0040, "ecall_mepc");
    rd(12'h342, 64'd11,        "ecall_mcause");
    rd(12'h300, 64'ha00001880, "ecall_mstatus");
    do_req(2'b10, 3'b000, 12'h000, 64'd0, 64'd0);
    chk("mret_redirect",    {63'd0, redirect_o}, 64'd1);
    chk("mret_redirect_pc", redirect_pc_o,       64'h8000_0040);
    rd(12'h300, 64'ha00001888, "mret_mstatus");

    // Vectored timer interrupt
    do_req(2'b00, 3'b101, 12'h305, 64'd0, 64'h8000_0103);
    chk("mtvec_old", rdata_o, 64'h8000_0100);
    rd(12'h305, 64'h8000_0101, "mtvec_bit1_masked");
    do_req(2'b00, 3'b001, 12'h304, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(12'h304, 64'h80, "mie_masked");
    mtip_i = 1'b1;
    rd(12'h344, 64'h80, "mip_mtip");
    chk("irq_high", {63'd0, irq_o}, 64'd1);
    @(posedge clk); #1;
    irq_ack_i = 1'b1; pc_i = 64'h8000_0200;
    #1;
    chk("irq_ack_ready", {63'd0, ready_o}, 64'd0);
    @(posedge clk); #1;
    irq_ack_i = 1'b0;
    $display("[TB] irq ack pc=8000_0200 -> redir=%0d pc=%h rvalid=%0d irq=%0d",
             redirect_o, redirect_pc_o, rvalid_o, irq_o);
    chk("irq_redirect",    {63'd0, redirect_o}, 64'd1);
    chk("irq_redirect_pc", redirect_pc_o,       64'h8000_011c);
    chk("irq_no_rvalid",   {63'd0, rvalid_o},   64'd0);
    chk("irq_low_after",   {63'd0, irq_o},      64'd0);
    rd(12'h342, 64'h8000_0000_0000_0007, "irq_mcause");
    rd(12'h341, 64'h8000_0200,           "irq_mepc");
    rd(12'h300, 64'ha00001880,           "irq_mstatus");

    // Request colliding with interrupt acknowledge
    do_req(2'b00, 3'b010, 12'h300, 64'd0, 64'h8);
    chk("mie_visible_irq", {63'd0, irq_o}, 64'd1);
    @(posedge clk); #1;
    valid_i = 1'b1; cmd_i = 2'b00; func3_i = 3'b010; addr_i = 12'h340; data_i = 64'd0;
    irq_ack_i = 1'b1; pc_i = 64'h8000_0300;
    #1;
    chk("coll_ready_low", {63'd0, ready_o}, 64'd0);
    @(posedge clk); #1;
    irq_ack_i = 1'b0;
    chk("coll_redirect",   {63'd0, redirect_o}, 64'd1);
    chk("coll_no_rvalid",  {63'd0, rvalid_o},   64'd0);
    chk("coll_resp_ready", {63'd0, ready_o},    64'd0);
    @(posedge clk); #1;
    chk("coll_idle_ready", {63'd0, ready_o}, 64'd1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    $display("[TB] collided req -> rvalid=%0d rdata=%h", rvalid_o, rdata_o);
    chk("coll_rvalid", {63'd0, rvalid_o}, 64'd1);
    chk("coll_rdata",  rdata_o,           64'h1234);
    mtip_i = 1'b0;

    // Illegal requests
    do_req(2'b00, 3'b001, 12'h7C0, 64'd0, 64'd5);
    chk("ill_addr",        {63'd0, illegal_o}, 64'd1);
    chk("ill_addr_rdata",  rdata_o,            64'd0);
    chk("ill_addr_rvalid", {63'd0, rvalid_o},  64'd1);
    do_req(2'b00, 3'b000, 12'h340, 64'd0, 64'hFF);
    chk("ill_f3",  {63'd0, illegal_o}, 64'd1);
    do_req(2'b11, 3'b001, 12'h340, 64'd0, 64'hFF);
    chk("ill_cmd", {63'd0, illegal_o}, 64'd1);
    chk("ill_cmd_rdata", rdata_o, 64'd0);
    rd(12'h340, 64'h1234, "ill_no_change");

    // mcycle write precedence and counting
    do_req(2'b00, 3'b001, 12'hB00, 64'd0, 64'd100);
    @(posedge clk);
    rd(12'hB00, 64'd102, "mcycle_count");

    // Reset during RESP
    do_req(2'b01, 3'b000, 12'h000, 64'h8000_0500, 64'd0);
    chk("pre_rst_redirect_pc", redirect_pc_o, 64'h8000_0100);
    rst = 1'b1; #1;
    chk("rst_mid_redirect", {63'd0, redirect_o}, 64'd0);
    chk("rst_mid_rvalid",   {63'd0, rvalid_o},   64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_redirect", {63'd0, redirect_o}, 64'd0);
    chk("post_rst_rvalid",   {63'd0, rvalid_o},   64'd0);
    rd(12'hB00, 64'd2,         "mcycle_restart");
    rd(12'h340, 64'd0,         "rst_mscratch");
    rd(12'h305, 64'd0,         "rst_mtvec");
    rd(12'h300, 64'ha00001800, "rst_mstatus");
    rd(12'h341, 64'd0,         "rst_mepc");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ysyx_22041412_csr_file.md
# ysyx_22041412_csr_file

Parametrised machine-mode CSR file and trap sequencer for the ysyx_22041412 core, sitting beside the execute stage. It serves Zicsr instructions over a valid/ready handshake, sequences ecall, mret and machine-timer-interrupt entry with full mstatus MIE/MPIE stacking, and drives a PC redirect to the fetch stage. It replaces the fixed 64-bit, 3-bit-indexed CSR block with full 12-bit addressing, width parameters, a free-running mcycle and a timer-interrupt path.

## Interface
- XLEN, 64, data width of every CSR and PC port
- MSTATUS_RST, 'ha00001800, reset value of mstatus
- MTVEC_RST, 0, reset value of mtvec
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- valid_i  in  1  request present
- ready_o  out  1  block can accept a request this cycle
- cmd_i  in  2  00 CSR op, 01 ecall, 10 mret, 11 reserved (illegal)
- func3_i  in  3  Zicsr funct3
- addr_i  in  12  CSR address
- pc_i  in  XLEN  PC of the request, or of the interrupted instruction on irq_ack_i
- data_i  in  XLEN  rs1 value or zero-extended uimm
- rvalid_o  out  1  one-cycle response pulse
- rdata_o  out  XLEN  old CSR value; valid with rvalid_o
- illegal_o  out  1  request was illegal; valid with rvalid_o
- redirect_o  out  1  one-cycle pulse, fetch must jump
- redirect_pc_o  out  XLEN  jump target; valid with redirect_o
- mtip_i  in  1  machine timer pending, level
- irq_o  out  1  interrupt ready to be taken: mstatus.MIE & mie.MTIE & mip.MTIP
- irq_ack_i  in  1  core takes the interrupt this cycle

## Operation
- CSR map: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344, mcycle 0xB00.
- mstatus: only MIE (bit 3) and MPIE (bit 7) are writable. All other bits hold MSTATUS_RST, including MPP = 3.
- mie: only MTIE (bit 7) is writable.
- mip: MTIP (bit 7) mirrors mtip_i. Writes to mip are ignored.
- mtvec: bit 1 is forced 0 on write.
- mepc: bits 1:0 are forced 0 on write.
- mcycle increments every cycle. A write to mcycle takes precedence over the increment in that cycle.
- Zicsr funct3 001/101 write data_i.
- Zicsr funct3 010/110 write old | data_i.
- Zicsr funct3 011/111 write old & ~data_i.
- For funct3 010, 011, 110 and 111, data_i == 0 suppresses the write; the read still happens.
- Illegal requests: funct3 000/100 with cmd 00, an unmapped address, or cmd 11. They set illegal_o, return rdata_o = 0 and change no state.
- ecall:
  - mepc <= pc_i; mcause <= 11.
  - MPIE <= MIE; MIE <= 0.
  - Redirect to {mtvec[XLEN-1:2], 2'b00}.
- mret:
  - MIE <= MPIE; MPIE <= 1.
  - Redirect to mepc.
- Interrupt entry on irq_ack_i:
  - mepc <= pc_i; mcause <= {1'b1, (XLEN-1)'d7}.
  - MIE/MPIE are stacked as for ecall.
  - Redirect to base, or to base + 28 when mtvec[0] = 1 (vectored mode).
  - irq_ack_i with irq_o low is ignored.
- FSM with two states:
  - IDLE: ready_o = !irq_ack_i.
  - RESP: ready_o = 0. Returns to IDLE unconditionally.
  - A request is accepted when valid_i & ready_o. Acceptance moves the FSM IDLE -> RESP.
  - irq_ack_i in IDLE also moves the FSM to RESP.

## Timing
- Accept at edge N: all CSR updates commit at edge N.
- Cycle N+1 (RESP):
  - rvalid_o = 1 with rdata_o = the pre-write value.
  - redirect_o pulses for ecall, mret and interrupts.
  - rvalid_o is not asserted for irq entry.
- Throughput is one request per 2 cycles.
- Simultaneous valid_i and irq_ack_i in IDLE: the interrupt wins. ready_o is low, and the request is accepted after RESP.
- A read of mip reflects mtip_i sampled at the accept edge.
- A CSR op writing mstatus.MIE is visible on irq_o from cycle N+1.
- Reset state, asserted immediately and asynchronously:
  - FSM in IDLE.
  - ready_o = 0 while rst is high, 1 after release.
  - rvalid_o, illegal_o, redirect_o, irq_o = 0.
  - rdata_o and redirect_pc_o = 0.
  - mstatus = MSTATUS_RST, mtvec = MTVEC_RST; all other CSRs = 0.
- Reset during RESP drops the pending response and redirect.

## Test plan
- Basic read/write:
  - After reset, CSRRW 0x340 with data_i = 'h1234 gives rvalid_o at N+1 with rdata_o = 0.
  - A following CSRRS 0x340 with data_i = 0 returns 'h1234 and mscratch is unchanged.
- mstatus masking: CSRRS 0x300 with data_i = all ones returns 'ha00001800; a re-read returns 'ha00001888.
- ecall and mret:
  - mtvec = 'h8000_0100; ecall at pc 'h8000_0040 gives redirect_pc_o = 'h8000_0100, mepc = 'h8000_0040, mcause = 11, MIE = 0, MPIE = old MIE.
  - A following mret redirects to 'h8000_0040 and restores MIE.
- Vectored interrupt:
  - mtvec = 'h8000_0101, MIE = 1, MTIE = 1, mtip_i = 1 gives irq_o = 1.
  - irq_ack_i at pc 'h8000_0200 gives redirect_pc_o = 'h8000_011c, mcause MSB = 1, cause = 7, irq_o low the next cycle.
- Collision and illegal requests:
  - valid_i with irq_ack_i in the same cycle: the request is stalled one extra cycle, then completes.
  - CSR op to address 0x7C0 gives illegal_o = 1, rdata_o = 0, no state change.
- Reset and mcycle:
  - rst asserted mid-RESP: no rvalid_o or redirect_o after release; mcycle restarts from 0.
  - CSRRW 0xB00 with data_i = 100 followed by a read 2 cycles later returns 102.
